lcd_refresh_scheduler: RTL and testbench

Owns a 32-cell (2 rows × 16 columns) shadow copy of the character LCD contents and sequences the single-character LCD driver to keep the panel in sync. Client logic writes characters into the shadow buffer at any rate. The scheduler tracks which cells have changed and issues one START/ADDRESS/CHARACTER transaction per changed cell, honouring the driver's BUSY handshake. It sits between application logic (game/UI FSMs) and the LCD driver.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_rr_pick.sv | 30 +++
 rtl/lcd_refresh_scheduler.sv | 168 ++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, scheduler state encoding and cell-to-DDRAM address mapping
// for the 2x16 character LCD refresh path.
package lcd_pkg;

  localparam int LCD_COLS  = 16;
  localparam int LCD_ROWS  = 2;
  localparam int LCD_CELLS = LCD_COLS * LCD_ROWS;
  localparam logic [7:0] LCD_BLANK     = 8'h20;
  localparam logic [7:0] LCD_ROW1_BASE = 8'h40;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  // idx[4] selects the row, idx[3:0] the column.
  function automatic logic [7:0] idx2addr(input logic [4:0] idx);
    logic [7:0] base;
    base = idx[4] ? LCD_ROW1_BASE : 8'h00;
    return base | {4'h0, idx[3:0]};
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Rotating priority encoder: returns the first set bit of i_dirty at or after
// i_ptr, wrapping from 31 back to 0.
module lcd_rr_pick
  import lcd_pkg::*;
(
  input  logic [31:0] i_dirty,
  input  logic [4:0]  i_ptr,
  output logic        o_valid,
  output logic [4:0]  o_idx
);

  logic [4:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest dirty cell wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 5'd0;
    w_cand  = 5'd0;
    for (int i = LCD_CELLS - 1; i >= 0; i--) begin
      w_cand = i_ptr + 5'(i);
      if (i_dirty[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Shadow buffer + dirty tracking that drives a single-character LCD driver.
// Optional bulk clear port is enabled with the LCD_SCHED_CLEAR_EN macro.
module lcd_refresh_scheduler
  import lcd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_idx,
  input  logic [7:0] i_wr_char,
`ifdef LCD_SCHED_CLEAR_EN
  input  logic       i_clear,
`endif
  input  logic       i_busy,
  output logic       o_start,
  output logic [7:0] o_address,
  output logic [7:0] o_character,
  output logic       o_idle,
  output logic       o_err
);

  logic [7:0]   r_buf [LCD_CELLS];
  logic [31:0]  r_dirty;
  logic [4:0]   r_ptr;
  logic [4:0]   r_issue_idx;
  logic [7:0]   r_timer;
  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         r_start;
  logic         r_err;
  logic [7:0]   r_addr;
  logic [7:0]   r_char;

  logic         w_pick_valid;
  logic [4:0]   w_pick_idx;
  logic         w_issue;
  logic         w_timeout;
  logic         w_done;
  logic         w_clear;
  logic         w_wr_dirty;
  logic [31:0]  w_clr_mask;
  logic [31:0]  w_rearm_mask;
  logic [31:0]  w_wr_mask;
  logic [31:0]  w_dirty_nxt;

`ifdef LCD_SCHED_CLEAR_EN
  assign w_clear = i_clear;
`else
  assign w_clear = 1'b0;
`endif

  lcd_rr_pick u_pick (
    .i_dirty (r_dirty),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // A write landing on the cell being issued keeps it dirty so the new value follows.
  assign w_wr_dirty   = i_wr_en && ((r_buf[i_wr_idx] != i_wr_char) ||
                                    (w_issue && (i_wr_idx == w_pick_idx)));
  assign w_clr_mask   = w_issue    ? (32'd1 << w_pick_idx)  : 32'd0;
  assign w_rearm_mask = w_timeout  ? (32'd1 << r_issue_idx) : 32'd0;
  assign w_wr_mask    = w_wr_dirty ? (32'd1 << i_wr_idx)    : 32'd0;
  assign w_dirty_nxt  = w_clear ? 32'hFFFF_FFFF
                                : ((r_dirty & ~w_clr_mask) | w_rearm_mask | w_wr_mask);

  // Next-state and transaction control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (!i_busy && w_pick_valid) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_ACK: begin
        if (i_busy) begin
          w_state_nxt = ST_DONE;
        end else if (r_timer == 8'(ACK_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_DONE: begin
        if (!i_busy) begin
          w_done      = 1'b1;
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_SCAN;
    else        r_state <= w_state_nxt;
  end

  // Shadow buffer and dirty vector.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < LCD_CELLS; i++) r_buf[i] <= LCD_BLANK;
      r_dirty <= 32'd0;
    end else begin
      if (w_clear) begin
        for (int i = 0; i < LCD_CELLS; i++) r_buf[i] <= LCD_BLANK;
      end else if (i_wr_en) begin
        r_buf[i_wr_idx] <= i_wr_char;
      end
      r_dirty <= w_dirty_nxt;
    end
  end

  // Scan pointer, issued index and acknowledge timer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr       <= 5'd0;
      r_issue_idx <= 5'd0;
      r_timer     <= 8'd0;
    end else begin
      if (w_done) r_ptr <= r_issue_idx + 5'd1;
      if (w_issue) begin
        r_issue_idx <= w_pick_idx;
        r_timer     <= 8'd0;
      end else if ((r_state == ST_ACK) && !i_busy) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  // Driver-facing outputs; address and character hold until the next issue.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 8'h00;
      r_char  <= LCD_BLANK;
    end else begin
      r_start <= w_issue;
      r_err   <= w_timeout;
      if (w_issue) begin
        r_addr <= idx2addr(w_pick_idx);
        r_char <= r_buf[w_pick_idx];
      end
    end
  end

  assign o_start     = r_start;
  assign o_err       = r_err;
  assign o_address   = r_addr;
  assign o_character = r_char;
  assign o_idle      = (r_state == ST_SCAN) && (r_dirty == 32'd0);

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed bench for lcd_refresh_scheduler with a small BUSY-handshake driver model.
// Define LCD_SCHED_CLEAR_EN to also exercise the bulk clear path.
module tb_lcd_refresh_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_wr_en;
  logic [4:0] i_wr_idx;
  logic [7:0] i_wr_char;
  logic       i_busy;
  logic       o_start;
  logic [7:0] o_address;
  logic [7:0] o_character;
  logic       o_idle;
  logic       o_err;
`ifdef LCD_SCHED_CLEAR_EN
  logic       i_clear = 1'b0;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  bit busy_hold = 1'b1;
  bit drv_dead  = 1'b0;
  int bcnt;

  typedef struct {
    logic [4:0] idx;
    logic [7:0] ch;
    bit         exp_issue;
    logic [7:0] exp_addr;
  } vec_t;
  vec_t vecs[7];

  lcd_refresh_scheduler dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (i_wr_en),
    .i_wr_idx    (i_wr_idx),
    .i_wr_char   (i_wr_char),
`ifdef LCD_SCHED_CLEAR_EN
    .i_clear     (i_clear),
`endif
    .i_busy      (i_busy),
    .o_start     (o_start),
    .o_address   (o_address),
    .o_character (o_character),
    .o_idle      (o_idle),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Driver model: BUSY for three cycles after each START, or stuck low when dead.
  initial begin
    i_busy = 1'b1;
    bcnt   = 0;
    forever begin
      @(negedge i_clk);
      if (busy_hold) begin
        i_busy = 1'b1;
      end else if (drv_dead) begin
        i_busy = 1'b0;
        bcnt   = 0;
      end else begin
        if (o_start) bcnt = 3;
        if (bcnt > 0) begin
          i_busy = 1'b1;
          bcnt--;
        end else begin
          i_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge i_clk);
      if (o_start === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got no o_start expected one within 300 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge i_clk);
      if (o_idle === 1'b1 && i_busy === 1'b0) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got busy scheduler expected idle within 500 cycles", name);
    end
  endtask

  task automatic write_cell(input logic [4:0] idx, input logic [7:0] ch);
    @(negedge i_clk);
    i_wr_en   = 1'b1;
    i_wr_idx  = idx;
    i_wr_char = ch;
    @(negedge i_clk);
    i_wr_en   = 1'b0;
  endtask

  initial begin
    int starts;
    int cyc;
    vecs[0] = '{5'd17, 8'h5A, 1'b1, 8'h41};
    vecs[1] = '{5'd17, 8'h5A, 1'b0, 8'h00};
    vecs[2] = '{5'd15, 8'h7E, 1'b1, 8'h0F};
    vecs[3] = '{5'd31, 8'h30, 1'b1, 8'h4F};
    vecs[4] = '{5'd16, 8'h2A, 1'b1, 8'h40};
    vecs[5] = '{5'd0,  8'h41, 1'b0, 8'h00};
    vecs[6] = '{5'd1,  8'h31, 1'b1, 8'h01};

    i_rst = 1'b0; i_wr_en = 1'b0; i_wr_idx = 5'd0; i_wr_char = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_start", {31'd0, o_start}, 32'd0);
    chk("rst_addr",  {24'd0, o_address}, 32'h00);
    chk("rst_char",  {24'd0, o_character}, 32'h20);
    chk("rst_err",   {31'd0, o_err}, 32'd0);
    chk("rst_idle",  {31'd0, o_idle}, 32'd1);
    i_rst = 1'b1;

    // Driver still initialising: nothing may be issued.
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_start === 1'b1) starts++;
    end
    chk("startup_nostart", starts, 0);
    chk("startup_idle", {31'd0, o_idle}, 32'd1);
    write_cell(5'd0, 8'h41);
    chk("startup_dirty", {31'd0, o_idle}, 32'd0);
    busy_hold = 1'b0;
    wait_start("startup_issue");
    chk("startup_addr", {24'd0, o_address}, 32'h00);
    chk("startup_char", {24'd0, o_character}, 32'h41);
    wait_idle("startup_idle_after");

    for (int v = 0; v < 7; v++) begin
      wait_idle("vec_pre_idle");
      write_cell(vecs[v].idx, vecs[v].ch);
      if (vecs[v].exp_issue) begin
        chk("vec_start_early", {31'd0, o_start}, 32'd0);
        @(negedge i_clk);
        chk("vec_start", {31'd0, o_start}, 32'd1);
        chk("vec_addr", {24'd0, o_address}, {24'd0, vecs[v].exp_addr});
        chk("vec_char", {24'd0, o_character}, {24'd0, vecs[v].ch});
        @(negedge i_clk);
        chk("vec_start_pulse", {31'd0, o_start}, 32'd0);
      end else begin
        starts = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge i_clk);
          if (o_start === 1'b1) starts++;
        end
        chk("vec_nostart", starts, 0);
        chk("vec_idle", {31'd0, o_idle}, 32'd1);
      end
    end
    wait_idle("vec_post_idle");

    // Pointer now 2: pending 3, 1, 30 must go out as 3, 30, 1.
    busy_hold = 1'b1;
    repeat (2) @(negedge i_clk);
    write_cell(5'd3, 8'h33);
    write_cell(5'd1, 8'h32);
    write_cell(5'd30, 8'h3E);
    busy_hold = 1'b0;
    wait_start("rr_first");
    chk("rr_first_addr", {24'd0, o_address}, 32'h03);
    chk("rr_first_char", {24'd0, o_character}, 32'h33);
    wait_start("rr_second");
    chk("rr_second_addr", {24'd0, o_address}, 32'h4E);
    chk("rr_second_char", {24'd0, o_character}, 32'h3E);
    wait_start("rr_third");
    chk("rr_third_addr", {24'd0, o_address}, 32'h01);
    chk("rr_third_char", {24'd0, o_character}, 32'h32);
    wait_idle("rr_idle");

    // Client rewrites cell 5 on the very edge it is issued.
    busy_hold = 1'b1;
    repeat (2) @(negedge i_clk);
    write_cell(5'd5, 8'h50);
    @(posedge i_clk);
    #1 busy_hold = 1'b0;
    @(negedge i_clk);
    #1;
    i_wr_en = 1'b1; i_wr_idx = 5'd5; i_wr_char = 8'h55;
    @(posedge i_clk);
    #1 i_wr_en = 1'b0;
    wait_start("coll_first");
    chk("coll_first_addr", {24'd0, o_address}, 32'h05);
    chk("coll_first_char", {24'd0, o_character}, 32'h50);
    wait_start("coll_second");
    chk("coll_second_addr", {24'd0, o_address}, 32'h05);
    chk("coll_second_char", {24'd0, o_character}, 32'h55);
    wait_idle("coll_idle");

    // Driver never acknowledges: error after 15 cycles, same cell re-issued.
    drv_dead = 1'b1;
    write_cell(5'd9, 8'h39);
    wait_start("to_issue");
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      cyc++;
      if (o_err === 1'b1) break;
    end
    chk("to_latency", cyc, 15);
    @(negedge i_clk);
    chk("to_err_pulse", {31'd0, o_err}, 32'd0);
    chk("to_reissue", {31'd0, o_start}, 32'd1);
    chk("to_reissue_addr", {24'd0, o_address}, 32'h09);
    chk("to_reissue_char", {24'd0, o_character}, 32'h39);
    drv_dead = 1'b0;
    wait_idle("to_idle");

    // Reset in the middle of a transaction.
    write_cell(5'd2, 8'h22);
    wait_start("mid_issue");
    i_rst = 1'b0;
    #1;
    chk("mid_rst_start", {31'd0, o_start}, 32'd0);
    chk("mid_rst_char", {24'd0, o_character}, 32'h20);
    chk("mid_rst_idle", {31'd0, o_idle}, 32'd1);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    wait_idle("mid_idle");

`ifdef LCD_SCHED_CLEAR_EN
    begin
      bit seen [256];
      int covered;
      int blanks;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      blanks = 0;
      @(negedge i_clk);
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      for (int t = 0; t < 32; t++) begin
        wait_start("clr_issue");
        seen[o_address] = 1'b1;
        if (o_character == 8'h20) blanks++;
      end
      covered = 0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 16; c++) begin
          a = (r == 1) ? 8'h40 + 8'(c) : 8'(c);
          if (seen[a]) covered++;
        end
      end
      chk("clr_blank", blanks, 32);
      chk("clr_cover", covered, 32);
      wait_idle("clr_idle");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
